// File: rtl/alu_pkg.sv
// Shared definitions for the 2-bit ALU datapath and its downstream stages.
//   accum_state_t : FSM states of the batch accumulator
//   ALU_RES_W     : width of the ALU result pair {C, O}
//   ALU_O_W       : width of the ALU O output
package alu_pkg;

  localparam int unsigned ALU_RES_W = 4;
  localparam int unsigned ALU_O_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } accum_state_t;

endpackage

// File: rtl/alu_accum.sv
// Batch accumulator downstream of the 2-bit ALU. Sums N_OPS ALU results
// ({in_c, in_o}, 0..15) into an ACC_W-bit register and presents the total
// with a sticky overflow flag on an output valid/ready handshake.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : one-cycle request to begin a batch (honoured in IDLE only)
//   in_valid/in_ready  : input handshake for one ALU result
//   in_o, in_c         : ALU result pair
//   out_valid/out_ready: output handshake for the batch total
//   out_sum, out_ovf   : batch total modulo 2^ACC_W, sticky carry-out flag
//   busy               : high while a batch is in progress or being held
module alu_accum
  import alu_pkg::*;
#(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned N_OPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALU_O_W-1:0] in_o,
  input  logic               in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(N_OPS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_OPS - 1);

  accum_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ALU_RES_W-1:0] operand;
  logic [ACC_W:0]       sum;

  // One extra bit on the adder captures the carry out of ACC_W bits.
  assign operand = {in_c, in_o};
  assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - ALU_RES_W){1'b0}}, operand};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // in_ready is constant 1 here, so in_valid alone marks a beat.
        if (in_valid) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come only from registers, never from inputs.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_alu_accum.sv
// Self-checking bench for alu_accum. Two instances (ACC_W=8 and ACC_W=5,
// both N_OPS=4) share every input so each batch is checked at both widths.
module tb_alu_accum;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_c, out_ready;
  logic [2:0] in_o;

  logic       r8, v8, o8, b8;
  logic [7:0] s8;
  logic       r5, v5, o5, b5;
  logic [4:0] s5;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_accum #(.ACC_W(8), .N_OPS(4)) dut8 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r8),
    .in_o(in_o), .in_c(in_c), .out_valid(v8), .out_ready(out_ready),
    .out_sum(s8), .out_ovf(o8), .busy(b8)
  );

  alu_accum #(.ACC_W(5), .N_OPS(4)) dut5 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(r5),
    .in_o(in_o), .in_c(in_c), .out_valid(v5), .out_ready(out_ready),
    .out_sum(s5), .out_ovf(o5), .busy(b5)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] val);
    in_valid = 1'b1;
    {in_c, in_o} = val;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_c = 1'b1; in_o = 3'b111;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({r8, v8, s8, o8, b8} !== 12'd0) begin
        failures++;
        $display("FAIL reset8[%0d]: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
                 i, r8, v8, s8, o8, b8);
      end
      checks++;
      if ({r5, v5, s5, o5, b5} !== 9'd0) begin
        failures++;
        $display("FAIL reset5[%0d]: got rdy=%b vld=%b sum=%0d ovf=%b busy=%b want all 0",
                 i, r5, v5, s5, o5, b5);
      end
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    pulse_start();
    checks++;
    if (r8 !== 1'b1 || b8 !== 1'b1) begin
      failures++;
      $display("FAIL basic_start: got rdy=%b busy=%b want 1 1", r8, b8);
    end
    beat(4'd3); beat(4'd5); beat(4'd6);
    checks++;
    if (v8 !== 1'b0 || r8 !== 1'b1) begin
      failures++;
      $display("FAIL basic_early: got vld=%b rdy=%b want 0 1", v8, r8);
    end
    beat(4'd12);
    checks++;
    if (v8 !== 1'b1 || r8 !== 1'b0 || s8 !== 8'd26 || o8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: got vld=%b rdy=%b sum=%0d ovf=%b want 1 0 26 0",
               v8, r8, s8, o8);
    end
    checks++;
    if (v5 !== 1'b1 || s5 !== 5'd26 || o5 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done5: got vld=%b sum=%0d ovf=%b want 1 26 0", v5, s5, o5);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (v8 !== 1'b0 || b8 !== 1'b0 || r8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: got vld=%b busy=%b rdy=%b want 0 0 0", v8, b8, r8);
    end
  endtask

  task automatic test_stall();
    logic [3:0] vals [4];
    vals = '{4'd3, 4'd5, 4'd6, 4'd12};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      beat(vals[i]);
      if (i < 3) begin
        cyc();
        checks++;
        if (r8 !== 1'b1 || v8 !== 1'b0) begin
          failures++;
          $display("FAIL stall_gap[%0d]: got rdy=%b vld=%b want 1 0", i, r8, v8);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (v8 !== 1'b1 || s8 !== 8'd26 || o8 !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got vld=%b sum=%0d ovf=%b want 1 26 0",
                 i, v8, s8, o8);
      end
      cyc();
    end
    checks++;
    if (v8 !== 1'b1 || s8 !== 8'd26) begin
      failures++;
      $display("FAIL stall_hold_end: got vld=%b sum=%0d want 1 26", v8, s8);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (v8 !== 1'b0 || b8 !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle: got vld=%b busy=%b want 0 0", v8, b8);
    end
  endtask

  task automatic test_overflow();
    pulse_start();
    beat(4'd12); beat(4'd12); beat(4'd12); beat(4'd0);
    checks++;
    if (v5 !== 1'b1 || s5 !== 5'd4 || o5 !== 1'b1) begin
      failures++;
      $display("FAIL ovf5: got vld=%b sum=%0d ovf=%b want 1 4 1", v5, s5, o5);
    end
    checks++;
    if (s8 !== 8'd36 || o8 !== 1'b0) begin
      failures++;
      $display("FAIL ovf8: got sum=%0d ovf=%b want 36 0", s8, o8);
    end
    // start in the handoff cycle must not launch a new batch
    out_ready = 1'b1; start = 1'b1;
    cyc();
    out_ready = 1'b0; start = 1'b0;
    checks++;
    if (b5 !== 1'b0 || r5 !== 1'b0 || v5 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_handoff_start: got busy=%b rdy=%b vld=%b want 0 0 0", b5, r5, v5);
    end
    pulse_start();
    beat(4'd1); beat(4'd1); beat(4'd1); beat(4'd1);
    checks++;
    if (v5 !== 1'b1 || s5 !== 5'd4 || o5 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got vld=%b sum=%0d ovf=%b want 1 4 0", v5, s5, o5);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_ignored();
    in_valid = 1'b1; in_c = 1'b0; in_o = 3'd5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (r8 !== 1'b0 || b8 !== 1'b0 || v8 !== 1'b0) begin
        failures++;
        $display("FAIL ign_idle[%0d]: got rdy=%b busy=%b vld=%b want 0 0 0", i, r8, b8, v8);
      end
    end
    in_valid = 1'b0;
    pulse_start();
    beat(4'd2); beat(4'd2);
    pulse_start();
    checks++;
    if (r8 !== 1'b1 || v8 !== 1'b0) begin
      failures++;
      $display("FAIL ign_start: got rdy=%b vld=%b want 1 0", r8, v8);
    end
    beat(4'd2); beat(4'd2);
    checks++;
    if (v8 !== 1'b1 || s8 !== 8'd8 || o8 !== 1'b0) begin
      failures++;
      $display("FAIL ign_sum: got vld=%b sum=%0d ovf=%b want 1 8 0", v8, s8, o8);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    beat(4'd7); beat(4'd7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (s8 !== 8'd0 || b8 !== 1'b0 || r8 !== 1'b0 || v8 !== 1'b0 || o8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got sum=%0d busy=%b rdy=%b vld=%b ovf=%b want 0 0 0 0 0",
               s8, b8, r8, v8, o8);
    end
    pulse_start();
    beat(4'd1); beat(4'd2); beat(4'd3);
    checks++;
    if (v8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_early: got vld=%b want 0", v8);
    end
    beat(4'd4);
    checks++;
    if (v8 !== 1'b1 || s8 !== 8'd10 || o8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_sum: got vld=%b sum=%0d ovf=%b want 1 10 0", v8, s8, o8);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (b8 !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle: got busy=%b want 0", b8);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_accum.md
# alu_accum

Batch accumulator directly downstream of the 2-bit ALU. Consumes the ALU result pair (3-bit `O`, carry `C`) over a valid/ready handshake. Sums a fixed-length batch of results into a wider register and presents the total with a sticky overflow flag on an output valid/ready handshake. This gives the ALU datapath a multi-operation reduction stage ahead of any result consumer.

## Interface
- `ACC_W`, default 8: accumulator and output sum width. Legal range is ≥ 5.
- `N_OPS`, default 4: ALU results accepted per batch. Legal range is ≥ 2.
- `clk` in, 1: single clock. All state updates on its rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `start` in, 1: single-cycle request to begin a batch.
- `in_valid` in, 1: ALU result valid.
- `in_ready` out, 1: block accepts a result this cycle.
- `in_o` in, 3: ALU `O` output.
- `in_c` in, 1: ALU `C` output.
- `out_valid` out, 1: batch total available.
- `out_ready` in, 1: consumer takes the total.
- `out_sum` out, ACC_W: batch total, modulo 2^ACC_W.
- `out_ovf` out, 1: sticky. Set if any addition in the batch carried out of ACC_W bits.
- `busy` out, 1: high in ACCUM and HOLD.

## Operation
- Operand value is `{in_c, in_o}`, a 4-bit unsigned value in the range 0..15. It is zero-extended to ACC_W+1 bits before the add. The ALU never produces more than 12; the block does not check this.
- FSM states are IDLE, ACCUM and HOLD.
- **IDLE**
  - `in_ready`=0 and `out_valid`=0.
  - On `start`=1: clear `acc`, the beat counter `cnt` and `ovf`, then go to ACCUM.
  - `in_valid` is ignored.
- **ACCUM**
  - `in_ready`=1.
  - On a beat (`in_valid` & `in_ready`): `acc` ← `acc` + operand, with the low ACC_W bits kept. `ovf` ← `ovf` | carry-out. `cnt` ← `cnt`+1.
  - If `cnt`==N_OPS-1 on the accepted beat, go to HOLD.
  - Cycles without `in_valid` leave all state unchanged.
  - `start` is ignored.
- **HOLD**
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum` and `out_ovf` are stable until `out_valid` & `out_ready`, then go to IDLE.
  - `start` is ignored, including in the handoff cycle. A new batch requires `start` in IDLE.
- `out_sum` is driven from `acc` and `out_ovf` from `ovf`. Both are registers, so their values are visible in every state. They are only meaningful while `out_valid`=1.
- `cnt` width is $clog2(N_OPS).
- **Reset**: takes effect in any state, including mid-batch or mid-HOLD. After the reset edge:
  - state = IDLE, `acc`=0, `cnt`=0, `ovf`=0.
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.
  - A partial batch is discarded.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- `start` sampled in cycle t gives `in_ready`=1 in cycle t+1.
- Final beat accepted in cycle t gives `out_valid`=1 in cycle t+1. `out_sum` includes that beat.
- Minimum batch duration is 1 (start) + N_OPS (beats) + 1 (HOLD, with `out_ready` held high) cycles.
- `out_valid`&`out_ready` in cycle t gives IDLE in cycle t+1. The earliest next `start` is accepted in cycle t+1.
- The upstream testbench driver updates operands on negedge-style `<=` timing. The block samples only on `posedge clk`.

## Structure
- Shared package `alu_pkg` holds:
  - enum `accum_state_t` {IDLE, ACCUM, HOLD};
  - constant `ALU_RES_W` = 4 (the `{C,O}` width);
  - constant `ALU_O_W` = 3.
- There is no sub-module; the counter, adder and FSM stay in one module.

## Test plan
- Reset: `rst` high for 2 cycles, with `in_valid`=1 and `start`=1 throughout → all outputs 0 and state IDLE on the cycle after each reset edge.
- Basic batch (ACC_W=8, N_OPS=4): `start`, then back-to-back beats of 3, 5, 6, 12 (`in_c`=1, `in_o`=100) → `out_valid`=1 the cycle after the 4th beat, `out_sum`=26, `out_ovf`=0.
- Stalls and backpressure: the same beats with one idle `in_valid` cycle between each, and `out_ready` low for 3 cycles in HOLD → sum stays 26 and stable, `out_valid` held, IDLE one cycle after `out_ready` rises.
- Overflow (ACC_W=5, N_OPS=4): beats 12, 12, 12, 0 → `out_sum`=4 (36 mod 32), `out_ovf`=1. Next batch 1, 1, 1, 1 → `out_sum`=4, `out_ovf`=0.
- Ignored inputs: `in_valid` pulses in IDLE → no accumulation. `start` pulsed in ACCUM after 2 beats → batch continues, and beats 2, 2, 2, 2 give `out_sum`=8.
- Reset mid-batch: after 2 beats of 7, assert `rst` for 1 cycle → IDLE with `out_sum`=0. The following batch 1, 2, 3, 4 gives `out_sum`=10, `out_ovf`=0.
